// File: rtl/onion_pwm_capture.sv
// Measures high time and rising-edge period of an external PWM line, decodes the duty code,
// flags off-nominal periods and an edge-less line. Glitch filter: ONION_PWM_CAP_GLITCH_FILTER_EN.
module onion_pwm_capture #(
    parameter int PWM_RESOLUTION_BITS = 8,
    parameter int COUNT_BITS          = 12,
    parameter int GLITCH_CYCLES       = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           PWM_i,
    input  logic                           enable,
    output logic [PWM_RESOLUTION_BITS-1:0] duty_cycle_o,
    output logic [COUNT_BITS-1:0]          high_count_o,
    output logic [COUNT_BITS-1:0]          period_o,
    output logic                           valid_o,
    output logic                           period_err_o,
    output logic                           stuck_o
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, STUCK} state_t;

    localparam logic [COUNT_BITS-1:0] CNT_MAX        = '1;
    localparam logic [COUNT_BITS-1:0] CNT_ONE        = COUNT_BITS'(1);
    localparam logic [COUNT_BITS-1:0] NOMINAL_PERIOD = CNT_ONE << PWM_RESOLUTION_BITS;

    if (COUNT_BITS <= PWM_RESOLUTION_BITS || GLITCH_CYCLES < 1) begin : g_bad_cfg
        $error("onion_pwm_capture: COUNT_BITS must exceed PWM_RESOLUTION_BITS, GLITCH_CYCLES >= 1");
    end

    logic                           sync1_q, sync1_d;
    logic                           sync2_q, sync2_d;
    logic                           pwm_d_q, pwm_d_d;
    state_t                         state_q, state_d;
    logic [COUNT_BITS-1:0]          per_cnt_q, per_cnt_d;
    logic [COUNT_BITS-1:0]          hi_cnt_q, hi_cnt_d;
    logic [PWM_RESOLUTION_BITS-1:0] duty_q, duty_d;
    logic [COUNT_BITS-1:0]          high_q, high_d;
    logic [COUNT_BITS-1:0]          period_q, period_d;
    logic                           valid_q, valid_d;
    logic                           err_q, err_d;
    logic                           stuck_q, stuck_d;

    logic                  pwm_s, pwm_f, rise, fall;
    logic [COUNT_BITS-1:0] per_inc, hi_inc;

    assign pwm_s = sync2_q;

`ifdef ONION_PWM_CAP_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    logic          filt_q, filt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    // Level follows pwm_s only once it has disagreed for GLITCH_CYCLES clocks in a row.
    always_comb begin
        filt_d = filt_q;
        gcnt_d = '0;
        if (pwm_s != filt_q) begin
            if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
                filt_d = pwm_s;
            end else begin
                gcnt_d = gcnt_q + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign pwm_f = filt_q;
`else
    assign pwm_f = pwm_s;
`endif

    assign rise = pwm_f & ~pwm_d_q;
    assign fall = ~pwm_f & pwm_d_q;

    always_comb begin
        sync1_d   = PWM_i;
        sync2_d   = sync1_q;
        pwm_d_d   = pwm_f;
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        duty_d    = duty_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        stuck_d   = stuck_q;
        per_inc   = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;
        // hi_cnt never outruns per_cnt, and per_cnt saturating forces a timeout first.
        hi_inc    = hi_cnt_q + COUNT_BITS'(pwm_f);

        if (!enable) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    state_d   = ARM;
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        // A rise always wins over a simultaneous timeout.
                        state_d   = MEASURE;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        stuck_d   = 1'b0;
                        if (state_q == MEASURE) begin
                            valid_d  = 1'b1;
                            period_d = per_cnt_q;
                            high_d   = hi_cnt_q;
                            err_d    = (per_cnt_q != NOMINAL_PERIOD);
                            if (per_cnt_q == NOMINAL_PERIOD) begin
                                duty_d = hi_cnt_q[PWM_RESOLUTION_BITS-1:0]
                                         - PWM_RESOLUTION_BITS'(1);
                            end
                        end
                    end else if (per_cnt_q == CNT_MAX) begin
                        state_d  = STUCK;
                        stuck_d  = 1'b1;
                        valid_d  = 1'b1;
                        period_d = CNT_MAX;
                        high_d   = {COUNT_BITS{pwm_f}};
                        duty_d   = {PWM_RESOLUTION_BITS{pwm_f}};
                        err_d    = 1'b0;
                    end else begin
                        per_cnt_d = per_inc;
                        hi_cnt_d  = hi_inc;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        stuck_d   = 1'b0;
                    end else if (fall) begin
                        // Re-arm so a line that stays low times out again with duty 0.
                        state_d   = ARM;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = '0;
                        stuck_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pwm_d_q   <= 1'b0;
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            duty_q    <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pwm_d_q   <= pwm_d_d;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            duty_q    <= duty_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            stuck_q   <= stuck_d;
        end
    end

    assign duty_cycle_o = duty_q;
    assign high_count_o = high_q;
    assign period_o     = period_q;
    assign valid_o      = valid_q;
    assign period_err_o = err_q;
    assign stuck_o      = stuck_q;

endmodule
